// File: rtl/cpu16_seq.sv
// Byte-wide fetch / decode / execute / writeback sequencer for a 16-bit core.
// One instruction is fetched as two bytes (high byte first) from the address in pc.
module cpu16_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_rdata,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [15:0] icnt,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    output logic [3:0]  rf_wa,
    output logic        rf_we,
    output logic [3:0]  alu_op,
    output logic        ab_le,
    output logic        out_le,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_HI = 3'd1,
        FETCH_LO = 3'd2,
        DECODE   = 3'd3,
        EXEC     = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6
    } state_t;

    state_t state_r;
    state_t state_next;

    always_ff @(posedge ck) begin
        if (rst) begin
            state_r <= IDLE;
            pc      <= RESET_PC;
            ir      <= 16'h0000;
            icnt    <= 16'h0000;
        end else begin
            state_r <= state_next;
            if (state_r == FETCH_HI && mem_rdy) begin
                ir[15:8] <= mem_rdata;
                pc       <= pc + 16'd1;
            end
            if (state_r == FETCH_LO && mem_rdy) begin
                ir[7:0] <= mem_rdata;
                pc      <= pc + 16'd1;
            end
            if (state_r == WB) begin
                icnt <= icnt + 16'd1;
            end
        end
    end

    // HALT has no exit here; only rst brings the core back to IDLE.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:     if (start)   state_next = FETCH_HI;
            FETCH_HI: if (mem_rdy) state_next = FETCH_LO;
            FETCH_LO: if (mem_rdy) state_next = DECODE;
            DECODE:   state_next = (ir[15:12] == HALT_OP) ? HALT : EXEC;
            EXEC:     state_next = WB;
            WB:       state_next = FETCH_HI;
            HALT:     state_next = HALT;
            default:  state_next = IDLE;
        endcase
    end

    assign mem_req  = (state_r == FETCH_HI) || (state_r == FETCH_LO);
    assign ab_le    = (state_r == DECODE);
    assign out_le   = (state_r == EXEC);
    assign rf_we    = (state_r == WB);
    assign halted   = (state_r == HALT);
    assign mem_addr = pc;
    assign rf_ra    = ir[7:4];
    assign rf_rb    = ir[3:0];
    assign rf_wa    = ir[11:8];
    assign alu_op   = ir[15:12];
    assign state    = state_r;

endmodule

// File: doc/cpu16_seq.md
CPU16_SEQ -- requirements
Module: cpu16_seq

Interface
REQ-001 The block SHALL have one clock, ck; reset is synchronous and active-high, rst.
REQ-002 The block SHALL have parameter RESET_PC, default 16'h0000, giving the pc value loaded on reset.
REQ-003 The block SHALL have parameter HALT_OP, default 4'hF, giving the opcode in ir[15:12] that halts the core.
REQ-004 The block SHALL have these ports, clock and reset first:
- ck  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  leave IDLE; sampled only in IDLE.
- mem_rdy  in  1  byte read complete this cycle; sampled only in FETCH_HI and FETCH_LO.
- mem_rdata  in  8  read byte; valid when mem_rdy=1.
- mem_req  out  1  byte read request.
- mem_addr  out  16  byte address; always equals pc.
- pc  out  16  program counter.
- ir  out  16  instruction register.
- icnt  out  16  retired-instruction counter.
- rf_ra  out  4  register file read port A, equals ir[7:4].
- rf_rb  out  4  register file read port B, equals ir[3:0].
- rf_wa  out  4  register file write address, equals ir[11:8].
- rf_we  out  1  register file write strobe.
- alu_op  out  4  ALU operation, equals ir[15:12].
- ab_le  out  1  strobe to latch A and B.
- out_le  out  1  strobe to latch OUT.
- halted  out  1  core is stopped.
- state  out  3  debug view of the FSM state.

Function
REQ-005 The FSM SHALL have these states and encodings: IDLE=0, FETCH_HI=1, FETCH_LO=2, DECODE=3, EXEC=4, WB=5, HALT=6.
REQ-006 IDLE SHALL go to FETCH_HI when start=1; otherwise it SHALL stay in IDLE.
REQ-007 In FETCH_HI the block SHALL drive mem_req=1; on mem_rdy=1 it SHALL load ir[15:8]=mem_rdata, increment pc, and go to FETCH_LO; otherwise it SHALL hold all registers.
REQ-008 FETCH_LO SHALL behave like FETCH_HI but SHALL load ir[7:0] and go to DECODE.
REQ-009 DECODE SHALL assert ab_le=1 for one cycle; it SHALL go to HALT if ir[15:12]=HALT_OP, otherwise to EXEC.
REQ-010 EXEC SHALL assert out_le=1 for one cycle and go to WB.
REQ-011 WB SHALL assert rf_we=1 for one cycle, increment icnt, and go to FETCH_HI.
REQ-012 HALT SHALL drive halted=1, SHALL be left only by rst, and SHALL ignore start and mem_rdy.
REQ-013 mem_req, ab_le, out_le, rf_we and halted SHALL be decoded from the state register only (Moore outputs); each SHALL be 0 in every state not named above for it.
REQ-014 With mem_rdy constantly 1, one instruction SHALL take exactly 5 cycles; each cycle mem_rdy=0 in a fetch state SHALL add one cycle.
REQ-015 pc and icnt SHALL wrap from 16'hFFFF to 16'h0000 without any flag.
REQ-016 A HALT_OP instruction SHALL NOT increment icnt and SHALL NOT assert rf_we.
REQ-017 While in a fetch state with mem_rdy=0, mem_addr and mem_req SHALL remain stable.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, ir=0 and icnt=0, and all strobes and halted SHALL be 0 in the next cycle.
REQ-019 Reset SHALL take priority over every transition, including mid-fetch and mid-WB; an aborted instruction SHALL NOT assert rf_we and SHALL NOT increment icnt.

Verification
REQ-020 Reset: rst=1 for one cycle from an arbitrary state -> state=0, pc=0, ir=0, icnt=0, all strobes 0.
REQ-021 Basic instruction: memory bytes 01 a2, mem_rdy=1, pulse start -> mem_addr 0 then 1; ir=16'h01a2; ab_le in cycle 3 with rf_ra=a and rf_rb=2; out_le in cycle 4 with alu_op=0; rf_we in cycle 5 with rf_wa=1; then icnt=1 and pc=2.
REQ-022 Wait states: mem_rdy=0 for 3 cycles in FETCH_HI -> mem_req=1 and mem_addr=0 held, pc unchanged, instruction takes 8 cycles.
REQ-023 Halt: bytes f0 00 -> halted=1 after DECODE, no rf_we, icnt=0, pc=2; a later start pulse leaves mem_req=0.
REQ-024 Reset during operation: rst=1 while in EXEC -> next cycle IDLE, rf_we never asserted, pc=RESET_PC, icnt unchanged from 0.
REQ-025 PC wrap: RESET_PC=16'hFFFF -> fetch addresses FFFF then 0000; pc=16'h0001 in DECODE.
